// File: rtl/blink128_dec_iter.sv
// blink128_dec_iter: iterative 128-bit block decryptor, one inverse round per cycle,
// round keys fetched externally by index (last key first).
module blink128_dec_iter #(
  parameter int NROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [4:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // inverse of the 4-bit cell S-box, entry v held in bits [4v+3:4v]
  localparam logic [63:0] INV_SBOX = 64'hA970_364B_D21C_8FE5;
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [127:0] st, sh, x, mk, y;
  logic last;
  // forward shuffle sends cell i to cell 5i mod 32, so pull it back from there
  for (genvar i = 0; i < 32; i++) begin : g_cell
    assign sh[4*i+:4] = st[4*((5*i)%32)+:4];
    assign y[4*i+:4]  = INV_SBOX[{mk[4*i+:4], 2'b00}+:4];
  end
  // undo the running XOR chain across the four 32-bit columns after removing the key
  assign x    = sh ^ rk;
  assign mk   = {x[127:96], x[95:64] ^ x[127:96], x[63:32] ^ x[95:64], x[31:0] ^ x[63:32]};
  assign last = cnt == 5'(NROUNDS - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        st  <= ciphertext;
        cnt <= '0;
      end else if (state == RUN) begin
        st  <= y;
        cnt <= last ? cnt : cnt + 5'd1;
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  assign in_ready  = rst_n && state == IDLE;
  assign busy      = rst_n && state == RUN;
  assign out_valid = rst_n && state == DONE;
  assign rk_idx    = busy ? 5'(NROUNDS - 1) - cnt : '0;
  assign plaintext = rst_n ? st : '0;
endmodule

// File: tb/tb_blink128_dec_iter.sv
// tb_blink128_dec_iter: round-trip checks against a forward-cipher model, plus an NROUNDS=1 build.
module tb_blink128_dec_iter;
  localparam int NR = 16;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
  logic [127:0] ciphertext = '0, rk, plaintext;
  logic [4:0] rk_idx;
  logic [127:0] keys [32];
  logic in_valid1 = 0, out_ready1 = 1, in_ready1, out_valid1, busy1;
  logic [127:0] ciphertext1 = '0, rk1 = '0, plaintext1;
  logic [4:0] rk_idx1;
  int errors = 0, checks = 0, cyc = 0;
  int phase = 0, rounds = 0, acc = 0, d = 0;
  logic [127:0] m_pt = '0, cur_p = '0;

  blink128_dec_iter #(.NROUNDS(NR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy));
  blink128_dec_iter #(.NROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .ciphertext(ciphertext1), .rk_idx(rk_idx1), .rk(rk1), .out_valid(out_valid1),
    .out_ready(out_ready1), .plaintext(plaintext1), .busy(busy1));

  always #5 clk = ~clk;
  assign rk = keys[rk_idx];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // forward round: S-box every cell, XOR-chain the columns, add key, shuffle cells
  function automatic logic [127:0] fwd(input logic [127:0] k, input logic [127:0] x);
    logic [127:0] s, m, o;
    logic [31:0] a, b, c, e;
    for (int i = 0; i < 32; i++) s[4*i+:4] = SBOX[x[4*i+:4]];
    a = s[127:96];
    b = a ^ s[95:64];
    c = b ^ s[63:32];
    e = c ^ s[31:0];
    m = {a, b, c, e} ^ k;
    for (int i = 0; i < 32; i++) o[4*((5*i)%32)+:4] = m[4*i+:4];
    return o;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] x = p;
    for (int r = 0; r < NR; r++) x = fwd(keys[r], x);
    return x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // cycle-level expectation: idle / decrypting (rounds done so far) / holding result
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) phase = 0;
    else if (phase == 0 && in_valid) begin phase = 1; rounds = 0; m_pt = cur_p; end
    else if (phase == 1) begin rounds++; if (rounds == NR) phase = 2; end
    else if (phase == 2 && out_ready) phase = 0;
  end

  always @(negedge clk) begin
    chk("in_ready", 128'(in_ready), 128'(rst_n && phase == 0));
    chk("busy", 128'(busy), 128'(rst_n && phase == 1));
    chk("out_valid", 128'(out_valid), 128'(rst_n && phase == 2));
    chk("rk_idx", 128'(rk_idx), (rst_n && phase == 1) ? 128'(NR - 1 - rounds) : 128'(0));
    if (!rst_n || phase == 2) chk("plaintext", plaintext, rst_n ? m_pt : 128'(0));
  end

  task automatic offer(input logic [127:0] p);
    int n = 0;
    cur_p = p;
    ciphertext = enc(p);
    in_valid = 1;
    while (!in_ready && n < 100) begin step(); n++; end
    if (n == 100) chk("accept_timeout", 128'(in_ready), 128'(1));
    acc = cyc;
    step();
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    if (n == 100) chk("out_timeout", 128'(out_valid), 128'(1));
    d = cyc;
  endtask

  task automatic run_block(input int bp);
    for (int i = 0; i < 32; i++) keys[i] = rand128();
    out_ready = (bp == 0);
    offer(rand128());
    in_valid = 0;
    wait_out();
    chk("latency", 128'(d - acc), 128'(NR + 1));
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      ciphertext = rand128();
      step();
    end
    in_valid = 0;
    out_ready = 1;
    step();
  endtask

  task automatic one_round(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n = 0;
    rk1 = k;
    ciphertext1 = c;
    in_valid1 = 1;
    while (!in_ready1 && n < 100) begin step(); n++; end
    acc = cyc;
    step();
    in_valid1 = 0;
    ciphertext1 = rand128();
    n = 0;
    while (!out_valid1 && n < 100) begin step(); n++; end
    chk("n1_latency", 128'(cyc - acc), 128'(2));
    chk("n1_plaintext", plaintext1, p);
    chk("n1_rk_idx_done", 128'(rk_idx1), 128'(0));
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) keys[i] = '0;
    repeat (3) step();
    rst_n = 1;
    chk("fwd_pin", fwd('0, '0), 128'h00CCC00C_CC000CC0_00CCC00C_CC000CC0);
    step();
    run_block(0);
    run_block(10);
    for (int t = 0; t < 5; t++) run_block($urandom_range(0, 5));
    // back-to-back with in_valid held high
    out_ready = 1;
    offer(rand128());
    cur_p = rand128();
    ciphertext = enc(cur_p);
    wait_out();
    acc = d;
    step();
    step();
    chk("b2b_busy", 128'(busy), 128'(1));
    chk("b2b_gap", 128'(cyc - acc), 128'(2));
    in_valid = 0;
    wait_out();
    step();
    // reset while cnt = 7
    offer(rand128());
    in_valid = 0;
    for (int n = 0; n < 100 && rk_idx != 5'(NR - 8); n++) step();
    chk("mid_rk_idx", 128'(rk_idx), 128'(NR - 8));
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    chk("post_reset_ready", 128'(in_ready), 128'(1));
    step();
    run_block(3);
    // single-round build
    one_round('0, 128'h00CCC00C_CC000CC0_00CCC00C_CC000CC0, '0);
    begin
      logic [127:0] k = rand128(), p = rand128();
      one_round(k, fwd(k, p), p);
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
